bwidow_dl_ctrl: RTL and testbench
=================================

Name: bwidow_dl_ctrl

Overview:
- Download/configuration front-end between hps_io ioctl outputs and BWIDOW_TOP.
- Demultiplexes the ioctl byte stream by index:
  - index 0: ROM image, re-timed onto the dn_addr/dn_data/dn_wr bus.
  - index 1: game-select byte, giving the one-hot mod_* flags.
  - index 254: DIP bytes sw[0..7].
- Generates the core hold-in-reset window, including the post-download settle time, and exports ROM-load status.

Parameters:
- ROM_AW, 16, width of dn_addr; ROM bytes at ioctl_addr >= 2**ROM_AW are dropped.
- SETTLE_CYCLES, 1024, clk_12 cycles the core stays held after a ROM download ends (range 1..65535).
- MOD_COUNT, 4, number of valid game-select codes (0..MOD_COUNT-1).

Ports:
- clk_12  in  1  system clock; same clock as hps_io clk_sys.
- reset  in  1  synchronous, active-high. Driven from RESET|status[0]|buttons[1] only, never from the download itself.
- ioctl_download  in  1  download active.
- ioctl_wr  in  1  one-cycle byte strobe.
- ioctl_addr  in  25  byte address.
- ioctl_dout  in  8  byte data.
- ioctl_index  in  8  download index.
- dn_addr  out  ROM_AW  ROM write address.
- dn_data  out  8  ROM write data.
- dn_wr  out  1  ROM write strobe.
- mod_bwidow  out  1  game-select flag, code 0.
- mod_gravitar  out  1  game-select flag, code 1.
- mod_lunarbat  out  1  game-select flag, code 2.
- mod_spacduel  out  1  game-select flag, code 3.
- sw0  out  8  DIP byte 0 (to SW_D4).
- sw1  out  8  DIP byte 1 (to SW_B4).
- sw2  out  8  DIP byte 2 (extra options).
- core_hold  out  1  hold core in reset.
- rom_valid  out  1  last ROM download completed cleanly.
- rom_overflow  out  1  at least one ROM byte was dropped in the current or last download.

Behaviour:
- Clock and reset: single clock, clk_12. reset is synchronous, active-high.
- Effect of reset:
  - state becomes IDLE.
  - dn_wr=0, dn_addr=0, dn_data=0.
  - core_hold=0, rom_valid=0, rom_overflow=0, settle counter=0.
  - mod code register and sw0..sw2 are NOT reset. At power-up they hold mod=0 (mod_bwidow=1, others 0) and sw=8'h00.
- FSM states: IDLE, ROM_DL, CFG_DL, SETTLE.
- Transitions:
  - IDLE -> ROM_DL on ioctl_download=1 with index 0. In the same edge: core_hold<=1, rom_valid<=0, rom_overflow<=0.
  - IDLE -> CFG_DL on ioctl_download=1 with index 1 or 254. core_hold is unchanged.
  - IDLE with ioctl_download=1 and any other index: stay IDLE and ignore all writes.
  - ROM_DL -> SETTLE on ioctl_download=0. Settle counter loads SETTLE_CYCLES-1. rom_valid is NOT yet set.
  - SETTLE counts down by 1 per cycle. At 0: state<=IDLE, core_hold<=0, and rom_valid<=~rom_overflow.
  - SETTLE: a new index-0 download re-enters ROM_DL. core_hold stays 1 and the rom flags clear again.
  - CFG_DL -> IDLE on ioctl_download=0.
- ROM path (ROM_DL only):
  - Qualifying write: ioctl_wr=1 and ioctl_addr[24:ROM_AW]==0.
  - Registers dn_addr<=ioctl_addr[ROM_AW-1:0] and dn_data<=ioctl_dout. dn_wr=1 for exactly one cycle, latency 1.
  - A non-qualifying write (high address bits set) gives dn_wr=0 and sets rom_overflow (sticky until the next ROM download start or reset).
  - dn_addr/dn_data hold their last value when dn_wr=0.
- Config path (CFG_DL only, ioctl_wr=1):
  - index 1, ioctl_addr==0: mod code <= ioctl_dout.
  - index 1, ioctl_addr!=0: ignored.
  - index 254, ioctl_addr[24:3]==0: sw[addr[2:0]] <= ioctl_dout. Only entries 0..2 are exported; entries 3..7 are written and discarded.
  - All other writes ignored. dn_wr stays 0 throughout.
- mod flags:
  - Registered decode of the mod code; update 1 cycle after the code changes.
  - Codes >= MOD_COUNT give all flags 0.
  - Exactly one or zero flags are high at any time.
- Simultaneous events:
  - ioctl_wr in the same cycle as the ioctl_download rising edge: the byte is processed under the new state.
  - ioctl_wr in the same cycle as the falling edge: the byte is dropped.
- Reset mid-ROM_DL: state IDLE, core_hold=0, rom_valid=0. Any remaining writes of that download are ignored until ioctl_download drops and rises again.

Decomposition:
- Package bwidow_dl_pkg holds:
  - dl_state_t enum.
  - IDX_ROM=8'd0, IDX_MOD=8'd1, IDX_DIP=8'd254.
  - MOD_BWIDOW..MOD_SPACDUEL code constants.
- One sub-module, bwidow_settle_timer: loadable down-counter with a done pulse, used for the SETTLE window.

Test Plan:
1. ROM load: index 0 download writes 4 bytes A5,5A,FF,00 at addr 0..3, then download falls.
   - dn_wr pulses with dn_addr 0..3 and matching data, each 1 cycle after ioctl_wr.
   - core_hold=1 throughout and for 1024 cycles after the fall.
   - Then core_hold=0 and rom_valid=1.
2. Overflow: ROM byte at ioctl_addr 25'h10000.
   - No dn_wr for that byte; rom_overflow=1.
   - After settle: rom_valid=0, core_hold=0.
3. Config downloads:
   - index 1 with byte 02 -> mod_lunarbat=1, others 0, and core_hold stays 0.
   - index 254 bytes 11,22,33 -> sw0=11, sw1=22, sw2=33.
   - index 1 with byte 07 -> all mod flags 0.
4. Reset mid-ROM_DL after 2 bytes:
   - Next cycle core_hold=0 and dn_wr=0.
   - Later writes in that same download produce no dn_wr.
   - sw0..sw2 and the mod flags are unchanged.
5. Re-download during SETTLE: core_hold never deasserts; rom_overflow clears on the new start.
6. Ignored index: index 3 download with writes -> no dn_wr, and no change to sw or mod.

Source files
------------

// File: rtl/bwidow_dl_pkg.sv
// Shared types and constants for the Black Widow download/configuration front-end.
package bwidow_dl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ROM_DL,
      ST_CFG_DL,
      ST_SETTLE
   } dl_state_t;

   localparam logic [7:0] IDX_ROM = 8'd0;
   localparam logic [7:0] IDX_MOD = 8'd1;
   localparam logic [7:0] IDX_DIP = 8'd254;

   localparam logic [7:0] MOD_BWIDOW   = 8'd0;
   localparam logic [7:0] MOD_GRAVITAR = 8'd1;
   localparam logic [7:0] MOD_LUNARBAT = 8'd2;
   localparam logic [7:0] MOD_SPACDUEL = 8'd3;

   // Bit i is set when code == i and i is a valid game code; out-of-range codes give all zeros.
   function automatic logic [3:0] mod_onehot(input logic [7:0] code, input int unsigned count);
      logic [3:0] r;
      r = '0;
      for (int unsigned i = 0; i < 4; i++) begin
         r[i] = (code == 8'(i)) && (i < count);
      end
      return r;
   endfunction

endpackage

// File: rtl/bwidow_settle_timer.sv
// Loadable down-counter; done is asserted while running with the count at zero.
module bwidow_settle_timer #(
   parameter int unsigned WIDTH = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [WIDTH-1:0] value,
   input  logic             run,
   output logic             done
);

   logic [WIDTH-1:0] count;

   always_ff @(posedge clk) begin
      if (reset) begin
         count <= '0;
      end else if (load) begin
         count <= value;
      end else if (run && (count != '0)) begin
         count <= count - 1'b1;
      end
   end

   assign done = run && (count == '0);

endmodule

// File: rtl/bwidow_dl_ctrl.sv
// Demultiplexes the hps_io ioctl byte stream into ROM writes, game select and DIP bytes,
// and holds the core in reset during and shortly after a ROM download.
module bwidow_dl_ctrl
   import bwidow_dl_pkg::*;
#(
   parameter int unsigned ROM_AW        = 16,
   parameter int unsigned SETTLE_CYCLES = 1024,
   parameter int unsigned MOD_COUNT     = 4
) (
   input  logic              clk_12,
   input  logic              reset,
   input  logic              ioctl_download,
   input  logic              ioctl_wr,
   input  logic [24:0]       ioctl_addr,
   input  logic [7:0]        ioctl_dout,
   input  logic [7:0]        ioctl_index,
   output logic [ROM_AW-1:0] dn_addr,
   output logic [7:0]        dn_data,
   output logic              dn_wr,
   output logic              mod_bwidow,
   output logic              mod_gravitar,
   output logic              mod_lunarbat,
   output logic              mod_spacduel,
   output logic [7:0]        sw0,
   output logic [7:0]        sw1,
   output logic [7:0]        sw2,
   output logic              core_hold,
   output logic              rom_valid,
   output logic              rom_overflow
);

   localparam logic [15:0] SETTLE_LOAD = 16'(SETTLE_CYCLES - 1);

   dl_state_t state;
   dl_state_t state_next;

   logic       dl_prev = 1'b0;
   logic       dl_start;
   logic       settle_done;
   logic       settle_load;
   logic       settle_end;
   logic       rom_start;
   logic       rom_wr;
   logic       cfg_wr;
   logic       addr_ok;

   logic [7:0]      mod_code  = MOD_BWIDOW;
   logic [3:0]      mod_flags = 4'b0001;
   logic [2:0][7:0] sw_q      = '0;

   // Starts are edge-qualified so a download interrupted by reset stays ignored until it restarts.
   always_ff @(posedge clk_12) begin
      dl_prev <= ioctl_download;
   end

   assign dl_start = ioctl_download && !dl_prev;

   always_ff @(posedge clk_12) begin
      if (reset) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      unique case (state)
         ST_IDLE: begin
            if (dl_start) begin
               if (ioctl_index == IDX_ROM) begin
                  state_next = ST_ROM_DL;
               end else if ((ioctl_index == IDX_MOD) || (ioctl_index == IDX_DIP)) begin
                  state_next = ST_CFG_DL;
               end
            end
         end
         ST_ROM_DL: begin
            if (!ioctl_download) state_next = ST_SETTLE;
         end
         ST_CFG_DL: begin
            if (!ioctl_download) state_next = ST_IDLE;
         end
         ST_SETTLE: begin
            if (dl_start && (ioctl_index == IDX_ROM)) begin
               state_next = ST_ROM_DL;
            end else if (settle_done) begin
               state_next = ST_IDLE;
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // Writes are qualified by the next state: a byte on the rising edge is taken, one on the falling edge is dropped.
   assign rom_wr      = ioctl_wr && (state_next == ST_ROM_DL);
   assign cfg_wr      = ioctl_wr && (state_next == ST_CFG_DL);
   assign addr_ok     = (ioctl_addr[24:ROM_AW] == '0);
   assign rom_start   = (state != ST_ROM_DL) && (state_next == ST_ROM_DL);
   assign settle_load = (state == ST_ROM_DL) && (state_next == ST_SETTLE);
   assign settle_end  = (state == ST_SETTLE) && (state_next == ST_IDLE);

   bwidow_settle_timer #(
      .WIDTH(16)
   ) u_settle (
      .clk   (clk_12),
      .reset (reset),
      .load  (settle_load),
      .value (SETTLE_LOAD),
      .run   (state == ST_SETTLE),
      .done  (settle_done)
   );

   always_ff @(posedge clk_12) begin
      if (reset) begin
         dn_wr        <= 1'b0;
         dn_addr      <= '0;
         dn_data      <= '0;
         core_hold    <= 1'b0;
         rom_valid    <= 1'b0;
         rom_overflow <= 1'b0;
      end else begin
         dn_wr <= rom_wr && addr_ok;
         if (rom_wr && addr_ok) begin
            dn_addr <= ioctl_addr[ROM_AW-1:0];
            dn_data <= ioctl_dout;
         end
         rom_overflow <= (rom_overflow && !rom_start) || (rom_wr && !addr_ok);
         if (rom_start) begin
            core_hold <= 1'b1;
            rom_valid <= 1'b0;
         end else if (settle_end) begin
            core_hold <= 1'b0;
            rom_valid <= ~rom_overflow;
         end
      end
   end

   // Configuration registers survive reset; only their power-up values are defined.
   always_ff @(posedge clk_12) begin
      if (cfg_wr) begin
         if ((ioctl_index == IDX_MOD) && (ioctl_addr == '0)) begin
            mod_code <= ioctl_dout;
         end
         if ((ioctl_index == IDX_DIP) && (ioctl_addr[24:3] == '0)) begin
            case (ioctl_addr[2:0])
               3'd0:    sw_q[0] <= ioctl_dout;
               3'd1:    sw_q[1] <= ioctl_dout;
               3'd2:    sw_q[2] <= ioctl_dout;
               default: ;
            endcase
         end
      end
      mod_flags <= mod_onehot(mod_code, MOD_COUNT);
   end

   assign mod_bwidow   = mod_flags[0];
   assign mod_gravitar = mod_flags[1];
   assign mod_lunarbat = mod_flags[2];
   assign mod_spacduel = mod_flags[3];

   assign sw0 = sw_q[0];
   assign sw1 = sw_q[1];
   assign sw2 = sw_q[2];

endmodule

// File: tb/tb_bwidow_dl_ctrl.sv
// Directed bench for bwidow_dl_ctrl: ROM load, overflow, config bytes, reset abort, re-download, ignored index.
module tb_bwidow_dl_ctrl;

   logic        clk_12 = 1'b0;
   logic        reset;
   logic        ioctl_download;
   logic        ioctl_wr;
   logic [24:0] ioctl_addr;
   logic [7:0]  ioctl_dout;
   logic [7:0]  ioctl_index;
   logic [15:0] dn_addr;
   logic [7:0]  dn_data;
   logic        dn_wr;
   logic        mod_bwidow, mod_gravitar, mod_lunarbat, mod_spacduel;
   logic [7:0]  sw0, sw1, sw2;
   logic        core_hold, rom_valid, rom_overflow;
   logic [3:0]  flags;

   int checks   = 0;
   int failures = 0;
   int n;
   int drops;

   assign flags = {mod_spacduel, mod_lunarbat, mod_gravitar, mod_bwidow};

   always #5 clk_12 = ~clk_12;

   bwidow_dl_ctrl #(
      .ROM_AW(16),
      .SETTLE_CYCLES(1024),
      .MOD_COUNT(4)
   ) dut (
      .clk_12         (clk_12),
      .reset          (reset),
      .ioctl_download (ioctl_download),
      .ioctl_wr       (ioctl_wr),
      .ioctl_addr     (ioctl_addr),
      .ioctl_dout     (ioctl_dout),
      .ioctl_index    (ioctl_index),
      .dn_addr        (dn_addr),
      .dn_data        (dn_data),
      .dn_wr          (dn_wr),
      .mod_bwidow     (mod_bwidow),
      .mod_gravitar   (mod_gravitar),
      .mod_lunarbat   (mod_lunarbat),
      .mod_spacduel   (mod_spacduel),
      .sw0            (sw0),
      .sw1            (sw1),
      .sw2            (sw2),
      .core_hold      (core_hold),
      .rom_valid      (rom_valid),
      .rom_overflow   (rom_overflow)
   );

   task automatic tick;
      @(posedge clk_12);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // One write strobe; when a ROM write is expected, address and data must follow one cycle later.
   task automatic rom_byte(input string tag, input logic [24:0] a, input logic [7:0] d, input logic exp_wr);
      ioctl_addr = a;
      ioctl_dout = d;
      ioctl_wr   = 1'b1;
      tick();
      chk({tag, "_dn_wr"}, 32'(dn_wr), 32'(exp_wr));
      if (exp_wr) begin
         chk({tag, "_dn_addr"}, 32'(dn_addr), 32'(a[15:0]));
         chk({tag, "_dn_data"}, 32'(dn_data), 32'(d));
      end
      ioctl_wr = 1'b0;
      tick();
      chk({tag, "_dn_wr_off"}, 32'(dn_wr), 32'd0);
   endtask

   task automatic cfg_byte(input logic [24:0] a, input logic [7:0] d);
      ioctl_addr = a;
      ioctl_dout = d;
      ioctl_wr   = 1'b1;
      tick();
      ioctl_wr = 1'b0;
      tick();
   endtask

   task automatic wait_release(output int cycles);
      cycles = 0;
      while (core_hold === 1'b1 && cycles < 2000) begin
         tick();
         cycles++;
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset          = 1'b1;
      ioctl_download = 1'b0;
      ioctl_wr       = 1'b0;
      ioctl_addr     = '0;
      ioctl_dout     = '0;
      ioctl_index    = '0;
      tick();
      tick();
      chk("rst_dn_wr",     32'(dn_wr), 32'd0);
      chk("rst_dn_addr",   32'(dn_addr), 32'd0);
      chk("rst_dn_data",   32'(dn_data), 32'd0);
      chk("rst_core_hold", 32'(core_hold), 32'd0);
      chk("rst_rom_valid", 32'(rom_valid), 32'd0);
      chk("rst_overflow",  32'(rom_overflow), 32'd0);
      chk("pwr_flags",     32'(flags), 32'h1);
      chk("pwr_sw0",       32'(sw0), 32'h00);
      reset = 1'b0;
      tick();

      // 1: clean ROM load
      ioctl_index    = 8'd0;
      ioctl_download = 1'b1;
      tick();
      chk("t1_hold_start", 32'(core_hold), 32'd1);
      rom_byte("t1_b0", 25'd0, 8'hA5, 1'b1);
      rom_byte("t1_b1", 25'd1, 8'h5A, 1'b1);
      rom_byte("t1_b2", 25'd2, 8'hFF, 1'b1);
      rom_byte("t1_b3", 25'd3, 8'h00, 1'b1);
      chk("t1_hold_dl", 32'(core_hold), 32'd1);
      ioctl_download = 1'b0;
      tick();
      chk("t1_hold_fall",  32'(core_hold), 32'd1);
      chk("t1_valid_fall", 32'(rom_valid), 32'd0);
      wait_release(n);
      chk("t1_settle_len", 32'(n), 32'd1024);
      chk("t1_hold_end",   32'(core_hold), 32'd0);
      chk("t1_valid_end",  32'(rom_valid), 32'd1);
      chk("t1_ovf_end",    32'(rom_overflow), 32'd0);

      // 2: out-of-range ROM byte
      ioctl_download = 1'b1;
      tick();
      chk("t2_valid_clr", 32'(rom_valid), 32'd0);
      rom_byte("t2_big", 25'h10000, 8'h77, 1'b0);
      chk("t2_ovf",     32'(rom_overflow), 32'd1);
      chk("t2_addr_kept", 32'(dn_addr), 32'd3);
      ioctl_download = 1'b0;
      tick();
      wait_release(n);
      chk("t2_settle_len", 32'(n), 32'd1024);
      chk("t2_valid",  32'(rom_valid), 32'd0);
      chk("t2_hold",   32'(core_hold), 32'd0);
      chk("t2_ovf_kept", 32'(rom_overflow), 32'd1);

      // 3: game select and DIP bytes; first byte coincides with the download rising edge
      ioctl_index    = 8'd1;
      ioctl_download = 1'b1;
      cfg_byte(25'd0, 8'h02);
      chk("t3_lunarbat", 32'(flags), 32'h4);
      chk("t3_hold",     32'(core_hold), 32'd0);
      chk("t3_dn_wr",    32'(dn_wr), 32'd0);
      cfg_byte(25'd1, 8'h03);
      tick();
      chk("t3_addr1_ign", 32'(flags), 32'h4);
      ioctl_download = 1'b0;
      tick();
      ioctl_download = 1'b1;
      cfg_byte(25'd0, 8'h07);
      chk("t3_code7", 32'(flags), 32'h0);
      ioctl_download = 1'b0;
      cfg_byte(25'd0, 8'h01);
      tick();
      chk("t3_fall_drop", 32'(flags), 32'h0);
      ioctl_download = 1'b1;
      cfg_byte(25'd0, 8'h03);
      ioctl_download = 1'b0;
      tick();
      chk("t3_spacduel", 32'(flags), 32'h8);
      ioctl_index    = 8'd254;
      ioctl_download = 1'b1;
      cfg_byte(25'd0, 8'h11);
      cfg_byte(25'd1, 8'h22);
      cfg_byte(25'd2, 8'h33);
      cfg_byte(25'd3, 8'h44);
      cfg_byte(25'd8, 8'h55);
      ioctl_download = 1'b0;
      tick();
      chk("t3_sw0", 32'(sw0), 32'h11);
      chk("t3_sw1", 32'(sw1), 32'h22);
      chk("t3_sw2", 32'(sw2), 32'h33);

      // 4: reset in the middle of a ROM download
      ioctl_index    = 8'd0;
      ioctl_download = 1'b1;
      tick();
      chk("t4_hold_start", 32'(core_hold), 32'd1);
      rom_byte("t4_b0", 25'd0, 8'h10, 1'b1);
      rom_byte("t4_b1", 25'd1, 8'h20, 1'b1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("t4_hold",    32'(core_hold), 32'd0);
      chk("t4_dn_wr",   32'(dn_wr), 32'd0);
      chk("t4_valid",   32'(rom_valid), 32'd0);
      chk("t4_dn_addr", 32'(dn_addr), 32'd0);
      rom_byte("t4_late", 25'd2, 8'h30, 1'b0);
      chk("t4_hold_late", 32'(core_hold), 32'd0);
      chk("t4_sw0",   32'(sw0), 32'h11);
      chk("t4_sw1",   32'(sw1), 32'h22);
      chk("t4_sw2",   32'(sw2), 32'h33);
      chk("t4_flags", 32'(flags), 32'h8);
      ioctl_download = 1'b0;
      tick();

      // 5: new ROM download while settling
      ioctl_download = 1'b1;
      tick();
      rom_byte("t5_big", 25'h1_0000, 8'h01, 1'b0);
      chk("t5_ovf_set", 32'(rom_overflow), 32'd1);
      ioctl_download = 1'b0;
      tick();
      drops = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (core_hold !== 1'b1) drops++;
      end
      ioctl_download = 1'b1;
      tick();
      if (core_hold !== 1'b1) drops++;
      chk("t5_ovf_clr", 32'(rom_overflow), 32'd0);
      rom_byte("t5_b5", 25'd5, 8'h3C, 1'b1);
      if (core_hold !== 1'b1) drops++;
      chk("t5_no_drop", 32'(drops), 32'd0);
      ioctl_download = 1'b0;
      tick();
      wait_release(n);
      chk("t5_settle_len", 32'(n), 32'd1024);
      chk("t5_valid", 32'(rom_valid), 32'd1);

      // 6: unknown index is ignored entirely
      ioctl_index    = 8'd3;
      ioctl_download = 1'b1;
      tick();
      rom_byte("t6_w0", 25'd0, 8'h99, 1'b0);
      rom_byte("t6_w1", 25'd1, 8'h98, 1'b0);
      chk("t6_hold", 32'(core_hold), 32'd0);
      ioctl_download = 1'b0;
      tick();
      tick();
      chk("t6_flags", 32'(flags), 32'h8);
      chk("t6_sw0",   32'(sw0), 32'h11);
      chk("t6_sw1",   32'(sw1), 32'h22);
      chk("t6_valid", 32'(rom_valid), 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
